// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: subtractor FSM encoding and a
// constant-foldable ceil(log2) helper for sizing index counters.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsmState_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: oDiff = iA - iB - iBorrow (mod 2).
// Ports: iA minuend bit, iB subtrahend bit, iBorrow borrow-in,
//        oDiff difference bit, oBorrow borrow-out.
module full_subtractor (
    input  logic iA,
    input  logic iB,
    input  logic iBorrow,
    output logic oDiff,
    output logic oBorrow
);

    assign oDiff   = iA ^ iB ^ iBorrow;
    // Borrow when B exceeds A, or when A==B and a borrow comes in
    assign oBorrow = (~iA & iB) | (~(iA ^ iB) & iBorrow);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// Multi-cycle subtractor computing A - B - iBorrow, DIGIT_WIDTH bits per
// clock, least-significant digit first, with a registered borrow between
// digits. Start/busy/done handshake.
// Ports: iClk, iRst_n (async active-low), iStart, iA, iB, iBorrow in;
//        oBusy (RUN), oDone (1-cycle pulse), oDiff, oBorrow (unsigned
//        borrow-out), oOverflow (two's-complement overflow) out.
module ripple_borrow_subtractor_seq
    import arith_pkg::*;
#(
    parameter int unsigned SUB_WIDTH   = 16,
    parameter int unsigned DIGIT_WIDTH = 4
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic [SUB_WIDTH-1:0] iA,
    input  logic [SUB_WIDTH-1:0] iB,
    input  logic                 iBorrow,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [SUB_WIDTH-1:0] oDiff,
    output logic                 oBorrow,
    output logic                 oOverflow
);

    localparam int unsigned NDIG  = SUB_WIDTH / DIGIT_WIDTH;
    localparam int unsigned IDX_W = (clog2(NDIG) > 0) ? clog2(NDIG) : 1;
    localparam int unsigned MSB   = SUB_WIDTH - 1;

    fsmState_t              state;
    fsmState_t              nextState;
    logic                   accept;
    logic                   lastDigit;

    logic [SUB_WIDTH-1:0]   aReg;
    logic [SUB_WIDTH-1:0]   bReg;
    logic                   aMsb;
    logic                   bMsb;
    logic                   brwReg;
    logic [IDX_W-1:0]       digitIdx;

    logic [DIGIT_WIDTH:0]   chain;
    logic [DIGIT_WIDTH-1:0] diffDigit;
    logic [SUB_WIDTH-1:0]   digitMask;

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and accept decode; iStart is only honoured in IDLE/DONE
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        lastDigit = (digitIdx == IDX_W'(NDIG - 1));
        case (state)
            IDLE: begin
                if (iStart) begin
                    nextState = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (lastDigit) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (iStart) begin
                    nextState = RUN;
                    accept    = 1'b1;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Per-digit ripple-borrow slice on the low digit of the shifting operands
    assign chain[0] = brwReg;
    for (genvar i = 0; i < DIGIT_WIDTH; i++) begin : gCell
        full_subtractor uCell (
            .iA      (aReg[i]),
            .iB      (bReg[i]),
            .iBorrow (chain[i]),
            .oDiff   (diffDigit[i]),
            .oBorrow (chain[i+1])
        );
    end

    // Result-lane mask selecting oDiff[digitIdx*DW +: DW]
    for (genvar k = 0; k < NDIG; k++) begin : gMask
        assign digitMask[k*DIGIT_WIDTH +: DIGIT_WIDTH] =
            {DIGIT_WIDTH{digitIdx == IDX_W'(k)}};
    end

    // Datapath, handshake and flag registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            aReg      <= '0;
            bReg      <= '0;
            aMsb      <= 1'b0;
            bMsb      <= 1'b0;
            brwReg    <= 1'b0;
            digitIdx  <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oDiff     <= '0;
            oBorrow   <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            oBusy <= (nextState == RUN);
            oDone <= (nextState == DONE);
            if (accept) begin
                aReg      <= iA;
                bReg      <= iB;
                aMsb      <= iA[MSB];
                bMsb      <= iB[MSB];
                brwReg    <= iBorrow;
                digitIdx  <= '0;
                oDiff     <= '0;
                oBorrow   <= 1'b0;
                oOverflow <= 1'b0;
            end else if (state == RUN) begin
                aReg     <= aReg >> DIGIT_WIDTH;
                bReg     <= bReg >> DIGIT_WIDTH;
                brwReg   <= chain[DIGIT_WIDTH];
                digitIdx <= digitIdx + IDX_W'(1);
                oDiff    <= (oDiff & ~digitMask) | ({NDIG{diffDigit}} & digitMask);
                if (lastDigit) begin
                    // Operand MSBs are kept aside since the shift has consumed them
                    oBorrow   <= chain[DIGIT_WIDTH];
                    oOverflow <= (aMsb != bMsb) & (diffDigit[DIGIT_WIDTH-1] != aMsb);
                end
            end
        end
    end

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Self-checking bench for ripple_borrow_subtractor_seq (16-bit, 4-bit digits).
module tb_ripple_borrow_subtractor_seq;

    logic        iClk;
    logic        iRst_n;
    logic        iStart;
    logic [15:0] iA;
    logic [15:0] iB;
    logic        iBorrow;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oDiff;
    logic        oBorrow;
    logic        oOverflow;

    int passCnt  = 0;
    int totalCnt = 0;

    ripple_borrow_subtractor_seq #(
        .SUB_WIDTH   (16),
        .DIGIT_WIDTH (4)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iA        (iA),
        .iB        (iB),
        .iBorrow   (iBorrow),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oDiff     (oDiff),
        .oBorrow   (oBorrow),
        .oOverflow (oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise iStart on a falling edge, drop it one cycle later, then wait for
    // oDone. lat counts falling edges from the one where iStart was raised.
    task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         output logic [15:0] d, output logic br, output logic ov,
                         output int lat);
        @(negedge iClk);
        iA = a; iB = b; iBorrow = bin; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        lat = 1;
        while (!oDone && lat < 30) begin
            @(negedge iClk);
            lat++;
        end
        d  = oDiff;
        br = oBorrow;
        ov = oOverflow;
    endtask

    logic [15:0] d, d1, d2;
    logic        br, ov, ov2;
    int          lat, doneCnt, t1, t2;
    logic [15:0] ra, rb;
    logic        rbin;
    logic [16:0] ref17;

    initial begin
        iRst_n = 1'b0; iStart = 1'b0; iA = '0; iB = '0; iBorrow = 1'b0;
        repeat (3) @(negedge iClk);
        checkEq("rst_busy", 32'(oBusy), 0);
        checkEq("rst_done", 32'(oDone), 0);
        checkEq("rst_diff", 32'(oDiff), 0);
        checkEq("rst_brw",  32'(oBorrow), 0);
        checkEq("rst_ovf",  32'(oOverflow), 0);
        iRst_n = 1'b1;
        @(negedge iClk);

        // 1. basic subtraction and latency
        runOp(16'h1234, 16'h0034, 1'b0, d, br, ov, lat);
        checkEq("t1_lat",  32'(lat), 5);
        checkEq("t1_diff", 32'(d), 32'h1200);
        checkEq("t1_brw",  32'(br), 0);
        checkEq("t1_ovf",  32'(ov), 0);
        @(negedge iClk);
        checkEq("t1_done_pulse", 32'(oDone), 0);
        repeat (2) @(negedge iClk);
        checkEq("t1_hold_diff", 32'(oDiff), 32'h1200);
        checkEq("t1_idle_busy", 32'(oBusy), 0);

        // 2. wrap-around borrow cases
        runOp(16'h0000, 16'h0001, 1'b0, d, br, ov, lat);
        checkEq("t2a_diff", 32'(d), 32'hFFFF);
        checkEq("t2a_brw",  32'(br), 1);
        checkEq("t2a_ovf",  32'(ov), 0);
        runOp(16'h0005, 16'h0005, 1'b1, d, br, ov, lat);
        checkEq("t2b_diff", 32'(d), 32'hFFFF);
        checkEq("t2b_brw",  32'(br), 1);
        checkEq("t2b_ovf",  32'(ov), 0);

        // 3. signed overflow
        runOp(16'h8000, 16'h0001, 1'b0, d, br, ov, lat);
        checkEq("t3a_diff", 32'(d), 32'h7FFF);
        checkEq("t3a_ovf",  32'(ov), 1);
        checkEq("t3a_brw",  32'(br), 0);
        runOp(16'h7FFF, 16'hFFFF, 1'b0, d, br, ov, lat);
        checkEq("t3b_diff", 32'(d), 32'h8000);
        checkEq("t3b_ovf",  32'(ov), 1);
        checkEq("t3b_brw",  32'(br), 1);

        // 4. iStart during RUN is ignored
        @(negedge iClk);
        iA = 16'h1234; iB = 16'h0034; iBorrow = 1'b0; iStart = 1'b1;
        doneCnt = 0; d = '0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge iClk);
            if (i == 1) begin
                iStart = 1'b0;
                checkEq("t4_busy", 32'(oBusy), 1);
                checkEq("t4_clr_diff", 32'(oDiff), 0);
            end
            if (i == 3) begin
                iA = 16'hFFFF; iB = 16'h0001; iBorrow = 1'b1; iStart = 1'b1;
            end
            if (i == 4) iStart = 1'b0;
            if (oBusy && oDone) checkEq("t4_busy_and_done", 1, 0);
            if (oDone) begin
                doneCnt++;
                d = oDiff;
            end
        end
        checkEq("t4_done_cnt", 32'(doneCnt), 1);
        checkEq("t4_diff", 32'(d), 32'h1200);

        // 5. back-to-back with iStart held through DONE
        @(negedge iClk);
        iA = 16'h1234; iB = 16'h0034; iBorrow = 1'b0; iStart = 1'b1;
        doneCnt = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0; ov2 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge iClk);
            if (oDone) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    t1 = i; d1 = oDiff;
                    iA = 16'h8000; iB = 16'h0001; iBorrow = 1'b0;
                end else if (doneCnt == 2) begin
                    t2 = i; d2 = oDiff; ov2 = oOverflow;
                    iStart = 1'b0;
                end
            end
        end
        iStart = 1'b0;
        checkEq("t5_done_cnt", 32'(doneCnt), 2);
        checkEq("t5_first_t", 32'(t1), 5);
        checkEq("t5_gap", 32'(t2 - t1), 5);
        checkEq("t5_diff1", 32'(d1), 32'h1200);
        checkEq("t5_diff2", 32'(d2), 32'h7FFF);
        checkEq("t5_ovf2", 32'(ov2), 1);

        // 6. reset mid-RUN aborts
        @(negedge iClk);
        iA = 16'hFFFF; iB = 16'h1111; iBorrow = 1'b0; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        checkEq("t6_busy_pre", 32'(oBusy), 1);
        iRst_n = 1'b0;
        #1;
        checkEq("t6_busy",  32'(oBusy), 0);
        checkEq("t6_done",  32'(oDone), 0);
        checkEq("t6_diff",  32'(oDiff), 0);
        checkEq("t6_brw",   32'(oBorrow), 0);
        checkEq("t6_ovf",   32'(oOverflow), 0);
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iClk);
            if (oDone) doneCnt++;
        end
        checkEq("t6_no_done", 32'(doneCnt), 0);
        runOp(16'hABCD, 16'h1234, 1'b1, d, br, ov, lat);
        checkEq("t6_lat",  32'(lat), 5);
        checkEq("t6_diff_after", 32'(d), 32'h9998);
        checkEq("t6_brw_after",  32'(br), 0);
        checkEq("t6_ovf_after",  32'(ov), 0);

        // Random operands against a wide-subtraction model
        for (int n = 0; n < 1000; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            if (n == 0) begin ra = 16'hFFFF; rb = 16'h0000; rbin = 1'b1; end
            if (n == 1) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
            ref17 = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
            runOp(ra, rb, rbin, d, br, ov, lat);
            checkEq("rnd_lat",  32'(lat), 5);
            checkEq("rnd_diff", 32'(d), 32'(ref17[15:0]));
            checkEq("rnd_brw",  32'(br), 32'(ref17[16]));
            checkEq("rnd_ovf",  32'(ov),
                    32'((ra[15] != rb[15]) && (ref17[15] != ra[15])));
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
